// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_WRITE,
        ARB_SETTLE,
        ARB_DRAIN
    } arb_state_t;

    localparam int unsigned ARB_TMR_W = 16;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] pick_idx,
    output logic          any
);

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            automatic int unsigned j = (32'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart transmitter among N_REQ byte streams.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned MSG_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               wr,
    input  logic               busy
);

    localparam int unsigned PW = ptr_width(N_REQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [ARB_TMR_W-1:0] TMR_LAST =
        (MSG_TIMEOUT == 0) ? '0 : ARB_TMR_W'(MSG_TIMEOUT - 1);

    arb_state_t           state;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        ptr;
    logic [ARB_TMR_W-1:0] timer;
    logic                 last_q;

    logic [N_REQ-1:0]     pick;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;
    logic [N_REQ-1:0]     src;
    logic [7:0]           sel_byte;
    logic                 sel_last;
    logic                 accept;
    logic [PW-1:0]        next_ptr;

    uart_tx_arbiter_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req      (req_valid),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // Ready is gated by reset so no byte is consumed while the arbiter is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && !busy) begin
            if (state == ARB_IDLE && pick_any)
                req_ready = pick;
            else if (state == ARB_OWNED)
                req_ready = grant & req_valid;
        end
    end

    assign accept   = |req_ready;
    assign src      = (state == ARB_IDLE) ? pick : grant;
    assign next_ptr = (owner == LAST_IDX) ? '0 : owner + PW'(1);

    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (src[i]) begin
                sel_byte = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            wr      <= 1'b0;
            tx_data <= '0;
            grant   <= '0;
            owner   <= '0;
            ptr     <= '0;
            timer   <= '0;
            last_q  <= 1'b0;
        end else begin
            wr <= 1'b0;
            case (state)
                ARB_IDLE, ARB_OWNED: begin
                    if (accept) begin
                        tx_data <= sel_byte;
                        last_q  <= sel_last;
                        timer   <= '0;
                        wr      <= 1'b1;
                        state   <= ARB_WRITE;
                        if (state == ARB_IDLE) begin
                            grant <= pick;
                            owner <= pick_idx;
                        end
                    end else if (state == ARB_OWNED) begin
                        if (MSG_TIMEOUT != 0 && timer == TMR_LAST) begin
                            grant <= '0;
                            ptr   <= next_ptr;
                            timer <= '0;
                            state <= ARB_IDLE;
                        end else begin
                            timer <= timer + ARB_TMR_W'(1);
                        end
                    end
                end
                ARB_WRITE:  state <= ARB_SETTLE;
                ARB_SETTLE: state <= ARB_DRAIN;
                ARB_DRAIN: begin
                    if (!busy) begin
                        if (last_q) begin
                            grant <= '0;
                            ptr   <= next_ptr;
                            state <= ARB_IDLE;
                        end else begin
                            timer <= '0;
                            state <= ARB_OWNED;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart busy stub and per-requester byte queues.
module tb_uart_tx_arbiter;

    localparam int unsigned BUSY_LEN = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        wr;
    logic        busy;

    logic        force_busy = 1'b0;
    int unsigned cnt = 0;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [7:0]  wlog[$];
    bit          wr_prev = 1'b0;
    bit          chk_early = 1'b0;
    int          wr_viol = 0;
    int          ready_viol = 0;
    int          early_viol = 0;
    int          total = 0;
    int          bad = 0;

    assign busy = force_busy | (cnt != 0);

    uart_tx_arbiter #(
        .N_REQ       (2),
        .MSG_TIMEOUT (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .wr        (wr),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    // Requester drivers present the queue heads away from the active edge.
    always @(negedge clk) begin
        req_valid[0] = (q0.size() != 0);
        {req_last[0], req_data[7:0]} = (q0.size() != 0) ? q0[0] : 9'h000;
        req_valid[1] = (q1.size() != 0);
        {req_last[1], req_data[15:8]} = (q1.size() != 0) ? q1[0] : 9'h000;
    end

    always @(posedge clk) begin
        if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
        if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
        if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 0) ready_viol++;
        if (chk_early && req_ready[1] && wlog.size() < 3) early_viol++;
        if (wr && wr_prev) wr_viol++;
        wr_prev = wr;
        if (wr) wlog.push_back(tx_data);
        if (wr) cnt <= BUSY_LEN;
        else if (cnt != 0) cnt <= cnt - 1;
    end

    function automatic logic [31:0] pack_log();
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (i < wlog.size()) r[31-8*i -: 8] = wlog[i];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (wlog.size() >= n && grant == 2'b00 && !busy && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", wr); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit seen = 1'b0;
        bit ok = 1'b0;
        int held = 0;
        int wrn = 0;
        do_reset();
        q0.push_back({1'b1, 8'h41});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wr) begin
                wrn++;
                seen = 1'b1;
                total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL single_data got=%h exp=41", tx_data); end
                total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant_wr got=%b exp=01", grant); end
            end else if (seen && grant == 2'b00) begin
                ok = 1'b1;
                break;
            end else if (seen && grant == 2'b01) begin
                held++;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL single_release got=timeout exp=grant 00"); end
        total++; if (held != BUSY_LEN + 1) begin bad++; $display("FAIL single_hold got=%0d exp=%0d", held, BUSY_LEN + 1); end
        total++; if (wrn != 1) begin bad++; $display("FAIL single_wr_count got=%0d exp=1", wrn); end
    endtask

    task automatic test_two();
        bit ok;
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 0) do_reset();
            wlog.delete();
            q0.push_back({1'b1, 8'h30});
            q1.push_back({1'b1, 8'h31});
            wait_done(2, ok);
            total++; if (!ok || wlog.size() != 2) begin bad++; $display("FAIL two_done rep=%0d got=%0d bytes exp=2", rep, wlog.size()); end
            total++; if (pack_log() !== 32'h3031_0000) begin bad++; $display("FAIL two_order rep=%0d got=%h exp=30310000", rep, pack_log()); end
        end
    endtask

    task automatic test_msg();
        bit ok;
        do_reset();
        early_viol = 0;
        chk_early = 1'b1;
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        q1.push_back({1'b1, 8'h5A});
        wait_done(4, ok);
        chk_early = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL msg_done got=timeout exp=4 bytes"); end
        total++; if (pack_log() !== 32'h4142_435A) begin bad++; $display("FAIL msg_order got=%h exp=4142435a", pack_log()); end
        total++; if (early_viol != 0) begin bad++; $display("FAIL msg_ready1_early got=%0d exp=0", early_viol); end
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        bit seen = 1'b0;
        int held = 0;
        do_reset();
        q0.push_back({1'b0, 8'h41});
        q1.push_back({1'b1, 8'h5A});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!seen && busy) seen = 1'b1;
            else if (seen && !busy) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL tmo_busy got=timeout exp=busy cycle"); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant == 2'b01) held++;
        end
        total++; if (held != 10) begin bad++; $display("FAIL tmo_owned got=%0d exp=10", held); end
        @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL tmo_revoke got=%b exp=00", grant); end
        @(negedge clk);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL tmo_next_owner got=%b exp=10", grant); end
        wait_done(2, ok);
        total++; if (!ok || pack_log() !== 32'h415A_0000) begin bad++; $display("FAIL tmo_wire got=%h exp=415a0000", pack_log()); end
    endtask

    task automatic test_busy_reset();
        bit ok;
        int rdy = 0;
        int wrn = 0;
        @(negedge clk);
        rst_n = 1'b0;
        force_busy = 1'b1;
        q0.push_back({1'b1, 8'h66});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
        repeat (10) begin
            @(negedge clk);
            if (req_ready != 2'b00) rdy++;
            if (wr) wrn++;
        end
        total++; if (rdy != 0) begin bad++; $display("FAIL busy_ready got=%0d exp=0", rdy); end
        total++; if (wrn != 0) begin bad++; $display("FAIL busy_wr got=%0d exp=0", wrn); end
        force_busy = 1'b0;
        wait_done(1, ok);
        total++; if (!ok || pack_log() !== 32'h6600_0000) begin bad++; $display("FAIL busy_accept got=%h exp=66000000", pack_log()); end
    endtask

    task automatic test_reset_drain();
        bit ok = 1'b0;
        int stray = 0;
        do_reset();
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wlog.size() == 1 && busy) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rd_first got=timeout exp=first byte"); end
        repeat (3) @(negedge clk);
        q1.push_back({1'b1, 8'h5A});
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rd_grant got=%b exp=00", grant); end
        total++; if (wr !== 1'b0) begin bad++; $display("FAIL rd_wr got=%b exp=0", wr); end
        rst_n = 1'b1;
        for (int k = 0; k < 100 && busy; k++) begin
            @(negedge clk);
            if (busy && (req_ready != 2'b00 || wr)) stray++;
        end
        total++; if (stray != 0 || busy) begin bad++; $display("FAIL rd_wait_busy got=%0d exp=0", stray); end
        wait_done(4, ok);
        total++; if (!ok || pack_log() !== 32'h4142_435A) begin bad++; $display("FAIL rd_order got=%h exp=4142435a", pack_log()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_msg();
        test_timeout();
        test_busy_reset();
        test_reset_drain();
        total++; if (ready_viol != 0) begin bad++; $display("FAIL ready_onehot got=%0d exp=0", ready_viol); end
        total++; if (wr_viol != 0) begin bad++; $display("FAIL wr_single_cycle got=%0d exp=0", wr_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
